// File: rtl/voice_allocator_if.sv
// Key/voice bus between the debounced push-button bank, the voice allocator
// and the oscillator/mixer datapath.
interface voice_allocator_if #(
  parameter int NUM_KEYS   = 21,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 5,
  parameter int VOICE_W    = 2
);
  logic                        en;
  logic [NUM_KEYS-1:0]         pb;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic                        note_on;
  logic                        note_off;
  logic                        steal;
  logic [VOICE_W-1:0]          evt_voice;
  logic [KEY_W-1:0]            evt_key;
  logic [KEY_W-1:0]            scan_idx;

  modport master (
    output en, pb,
    input  voice_active, voice_key, note_on, note_off, steal, evt_voice, evt_key, scan_idx
  );

  modport slave (
    input  en, pb,
    output voice_active, voice_key, note_on, note_off, steal, evt_voice, evt_key, scan_idx
  );
endinterface

// File: rtl/voice_allocator.sv
// Round-robin key scanner that hands NUM_VOICES oscillator voices to pressed
// keys, stealing the oldest voice when all are busy.
module voice_allocator #(
  parameter int NUM_KEYS   = 21,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 5,
  parameter int VOICE_W    = 2
) (
  input  logic             hwclk,
  input  logic             reset,
  voice_allocator_if.slave bus
);

  localparam logic [KEY_W-1:0]   LAST_KEY = KEY_W'(NUM_KEYS - 1);
  localparam logic [VOICE_W-1:0] AGE_MAX  = VOICE_W'(NUM_VOICES - 1);

  logic [KEY_W-1:0]            scan_idx;
  logic [NUM_KEYS-1:0]         prev;
  logic [NUM_VOICES-1:0]       voice_active;
  logic [NUM_VOICES*KEY_W-1:0] voice_key;
  logic [VOICE_W-1:0]          age [NUM_VOICES];
  logic                        note_on, note_off, steal;
  logic [VOICE_W-1:0]          evt_voice;
  logic [KEY_W-1:0]            evt_key;

  logic               cur_pb, press, release_key;
  logic               free_found, match_found;
  logic [VOICE_W-1:0] free_v, oldest_v, match_v, alloc_v;

  assign cur_pb      = bus.pb[scan_idx];
  assign press       = cur_pb & ~prev[scan_idx];
  assign release_key = ~cur_pb & prev[scan_idx];

  // Descending loops so the lowest index wins every priority decision.
  always_comb begin
    free_found  = 1'b0;
    free_v      = '0;
    match_found = 1'b0;
    match_v     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_v     = VOICE_W'(v);
      end
      if (voice_active[v] && voice_key[v*KEY_W +: KEY_W] == scan_idx) begin
        match_found = 1'b1;
        match_v     = VOICE_W'(v);
      end
    end
  end

  always_comb begin
    oldest_v = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > age[oldest_v]) oldest_v = VOICE_W'(v);
    end
  end

  assign alloc_v = free_found ? free_v : oldest_v;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      scan_idx     <= '0;
      prev         <= '0;
      voice_active <= '0;
      voice_key    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      steal        <= 1'b0;
      evt_voice    <= '0;
      evt_key      <= '0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      steal    <= 1'b0;
      if (bus.en) begin
        scan_idx       <= (scan_idx == LAST_KEY) ? '0 : scan_idx + 1'b1;
        prev[scan_idx] <= cur_pb;
        if (press) begin
          voice_active[alloc_v]                <= 1'b1;
          voice_key[alloc_v*KEY_W +: KEY_W]    <= scan_idx;
          note_on                              <= 1'b1;
          steal                                <= ~free_found;
          evt_voice                            <= alloc_v;
          evt_key                              <= scan_idx;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VOICE_W'(v) == alloc_v)
              age[v] <= '0;
            else if (voice_active[v] && age[v] != AGE_MAX)
              age[v] <= age[v] + 1'b1;
          end
        end else if (release_key && match_found) begin
          voice_active[match_v] <= 1'b0;
          age[match_v]          <= '0;
          note_off              <= 1'b1;
          evt_voice             <= match_v;
          evt_key               <= scan_idx;
        end
      end
    end
  end

  assign bus.scan_idx     = scan_idx;
  assign bus.voice_active = voice_active;
  assign bus.voice_key    = voice_key;
  assign bus.note_on      = note_on;
  assign bus.note_off     = note_off;
  assign bus.steal        = steal;
  assign bus.evt_voice    = evt_voice;
  assign bus.evt_key      = evt_key;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Arbiter that shares NUM_VOICES oscillator voices among NUM_KEYS push-button keys.
- Sits between the debounced pb bus and the oscillator/mixer datapath inside top.
- Scans keys round-robin one per cycle, detects press/release edges, and allocates a free voice on press.
- When no voice is free, steals the oldest active voice; frees the owning voice on release.

Parameters:
- NUM_KEYS, 21, number of key inputs (pb width)
- NUM_VOICES, 4, number of oscillator voices shared
- KEY_W, 5, width of key index, ceil(log2(NUM_KEYS))
- VOICE_W, 2, width of voice index, ceil(log2(NUM_VOICES))

Ports:
- hwclk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  scan enable; low freezes scan pointer and suppresses events
- pb  input  NUM_KEYS  debounced, synchronized key levels, 1 = pressed
- voice_active  output  NUM_VOICES  bit v = voice v currently owns a key
- voice_key  output  NUM_VOICES*KEY_W  key index owned by voice v, packed at [v*KEY_W +: KEY_W]
- note_on  output  1  one-cycle pulse: voice evt_voice assigned to key evt_key
- note_off  output  1  one-cycle pulse: voice evt_voice released
- steal  output  1  one-cycle pulse coincident with note_on when an active voice was taken
- evt_voice  output  VOICE_W  voice index of current event
- evt_key  output  KEY_W  key index of current event
- scan_idx  output  KEY_W  key currently being examined

Behaviour:
- Reset (hwclk edge with reset=1) clears all of the following:
  - scan_idx=0, prev key register=0.
  - voice_active=0, voice_key=0, all voice ages=0.
  - note_on/note_off/steal=0, evt_voice=0, evt_key=0.
- Reset mid-operation drops all voices silently, with no note_off pulses.
- Keys still held after reset register as new presses when next scanned.
- Scan, while en=1:
  - scan_idx increments by 1 each cycle, wrapping NUM_KEYS-1 -> 0.
  - Full scan period is NUM_KEYS cycles.
- Scan, while en=0:
  - scan_idx and all voice state hold.
  - Event pulses are 0.
- Each enabled cycle with scan_idx=i:
  - press = pb[i] & ~prev[i]; release = ~pb[i] & prev[i].
  - prev[i] <= pb[i]; only bit i of prev updates.
- Press handling, results visible the cycle after i is scanned:
  - If any voice is inactive, take the lowest-index inactive voice v.
  - Else take the oldest voice (max age; ties -> lowest index) and pulse steal=1.
  - Update: voice_active[v]=1, voice_key[v]=i.
  - Event outputs: note_on=1, evt_voice=v, evt_key=i.
  - Ages: age[v]=0; every other active voice's age increments, saturating at NUM_VOICES-1.
- Release handling:
  - If an active voice v has voice_key[v]==i: voice_active[v]=0, age[v]=0, note_off=1, evt_voice=v, evt_key=i.
  - If no voice matches (its voice was stolen), there is no event and no state change.
- At most one event per cycle, since only one key is examined.
- note_on and note_off are never high together.
- A stolen voice gets no separate note_off; note_on+steal implies retrigger.
- Latency: pb edge to event pulse is at most NUM_KEYS+1 cycles; exactly 1 cycle when the edge is present while the key is being scanned.
- pb changes between scans of the same key are not seen; a press+release shorter than one scan period may be missed. This is accepted.
- Registered outputs only; no combinational path from pb to outputs.
- Voice age is a VOICE_W-bit counter per voice.

Test Plan:
- Reset then pb=0 for 42 cycles -> scan_idx wraps 20->0 at cycle 21; no note_on, note_off or steal pulses; voice_active=0000.
- pb[3]=1 held -> one note_on with evt_key=3, evt_voice=0; voice_active=0001, voice_key[0]=3. Releasing pb[3] -> note_off, evt_voice=0, voice_active=0000.
- Hold keys 1,2,3,4 (allocated v0..v3), then press key 10 -> note_on+steal, evt_voice=0 (oldest, key 1); voice_key[0]=10. Releasing key 1 -> no event.
- Voices full with keys 1,2,3,4; release key 2 -> note_off v1. Then press key 7 -> note_on evt_voice=1, steal=0.
- With key 5 active, deassert en for 30 cycles while toggling pb[5] -> scan_idx frozen, no pulses. Reassert en with pb[5]=0 -> note_off key 5 when scanned.
- 3 voices active, pulse reset for 1 cycle with keys still held -> voice_active=0000 the next cycle, no note_off. Held keys are re-allocated as v0,v1,v2 in ascending key order within 21 cycles.
